// File: rtl/cond_unit.sv
// cond_unit: condition evaluation and flag register for the 32-bit CPU.
// Holds the architectural {N,Z,C,V} flags. Evaluates the instruction's
// condition field against the registered flags, and gates the decoder's
// PC/register/memory write requests with the result.
// Optional build macro: COND_SQUASH_CNT_EN adds a saturating counter of
// instructions that were squashed by a failed condition.
`timescale 1ns/1ps
module cond_unit #(
   parameter logic [3:0] FLAG_RST = 4'b0000,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
`ifdef COND_SQUASH_CNT_EN
   input  logic             squash_clr,
   output logic [CNT_W-1:0] squash_cnt,
`endif
   output logic             CondEx,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags
);

   logic [3:0] flags_q, flags_d;
   logic       n_f, z_f, c_f, v_f;
   logic       cond_ex;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Decode the condition field against the registered flags only; there is
   // deliberately no bypass from ALUFlags.
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = z_f;
         4'b0001: cond_ex = ~z_f;
         4'b0010: cond_ex = c_f;
         4'b0011: cond_ex = ~c_f;
         4'b0100: cond_ex = n_f;
         4'b0101: cond_ex = ~n_f;
         4'b0110: cond_ex = v_f;
         4'b0111: cond_ex = ~v_f;
         4'b1000: cond_ex = c_f & ~z_f;
         4'b1001: cond_ex = ~c_f | z_f;
         4'b1010: cond_ex = (n_f == v_f);
         4'b1011: cond_ex = (n_f != v_f);
         4'b1100: cond_ex = ~z_f & (n_f == v_f);
         4'b1101: cond_ex = z_f | (n_f != v_f);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;   // reserved encoding never executes
      endcase
   end

   // Next flags: each half updates independently, only for an executed
   // instruction, so a failed condition leaves the flags untouched.
   always_comb begin
      flags_d = flags_q;
      if (en && cond_ex) begin
         if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
         if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   // Flags register; reset discards any write pending in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) flags_q <= FLAG_RST;
      else       flags_q <= flags_d;
   end

   assign CondEx   = cond_ex;
   assign PCSrc    = PCS  & cond_ex & en;
   assign RegWrite = RegW & cond_ex & en;
   assign MemWrite = MemW & cond_ex & en;
   assign Flags    = flags_q;

`ifdef COND_SQUASH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             squashed;

   // A squash is a real instruction (some write requested) whose condition failed.
   assign squashed = en & ~cond_ex & (PCS | RegW | MemW | (FlagW != 2'b00));

   // Next count: clear wins over increment; saturate at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (squash_clr)                     cnt_d = '0;
      else if (squashed && (~cnt_q != '0)) cnt_d = cnt_q + 1'b1;
   end

   // Squash counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign squash_cnt = cnt_q;
`endif

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the ALU status interface. Captures the ALU's Negative/Zero/Carry/Overflow outputs into an architectural flags register, subject to write-enables.
- Evaluates the 4-bit condition field of the current instruction against the registered flags.
- Gates the decoder's PC/register/memory write requests so that failed-condition instructions retire as no-ops.
- Sits between the control decoder and the datapath in the 32-bit CPU.

Parameters:
- FLAG_RST, 4'b0000, reset value of the flags register {N,Z,C,V}.
- CNT_W, 16, width of the squash counter (used only when the optional feature is enabled).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  instruction-valid/advance; when low, no state changes and all write outputs are 0.
- Cond  input  4  condition field of the current instruction.
- ALUFlags  input  4  {Negative, Zero, Carry, Overflow} from the ALU for the current instruction.
- FlagW  input  2  [1] requests an N,Z update; [0] requests a C,V update.
- PCS  input  1  decoder PC-write request.
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- CondEx  output  1  condition passed, evaluated on the registered flags.
- PCSrc  output  1  PCS & CondEx & en.
- RegWrite  output  1  RegW & CondEx & en.
- MemWrite  output  1  MemW & CondEx & en.
- Flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset: on a clk edge with reset=1, Flags <= FLAG_RST; reset has priority over every other input. CondEx, PCSrc, RegWrite and MemWrite are combinational and follow the reset flag state in the same cycle.
- Condition decode uses the registered Flags, never ALUFlags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Flag write, at the clk edge with reset=0:
  - If en & CondEx & FlagW[1]: {N,Z} <= ALUFlags[3:2].
  - If en & CondEx & FlagW[0]: {C,V} <= ALUFlags[1:0].
  - The two halves are independent; either, both, or neither update.
- Latency: flags written by instruction i are visible to the condition of instruction i+1, one cycle later. There is no same-cycle bypass. An instruction's own condition uses the flags from before its write.
- A failed condition suppresses that instruction's flag update as well as PCSrc, RegWrite and MemWrite.
- en=0: Flags hold; all write outputs are 0; CondEx still reflects Cond vs Flags.
- Reset asserted mid-stream: flags return to FLAG_RST at the next edge. Any pending flag write in that cycle is discarded.
- Carry convention: C is the ALU's carry-out (subtraction C=1 means no borrow). This unit does not reinterpret it.

Optional Feature:
- Macro: COND_SQUASH_CNT_EN.
- Enabled:
  - Extra output squash_cnt [CNT_W-1:0].
  - Increments at each clk edge where en=1 and CondEx=0 and (PCS|RegW|MemW|FlagW!=0), i.e. a real instruction squashed by its condition.
  - Saturates at all-ones with no wrap.
  - Reset to 0 by reset.
  - Extra input squash_clr (1 bit) clears the counter synchronously. It has priority over increment and lower priority than reset.
- Disabled: neither port exists; no counter logic is present.

Test Plan:
1. Reset, then Cond=0000 (EQ), RegW=1 -> Flags=0000, CondEx=0, RegWrite=0. Cond=1110 (AL), RegW=1 -> RegWrite=1.
2. Subtract 5-4: ALUFlags=4'b0010, FlagW=11, Cond=1110, en=1 -> next cycle Flags=0010. Then Cond=0010 (CS) -> CondEx=1. Cond=1000 (HI) -> CondEx=1. Cond=0000 (EQ) -> CondEx=0.
3. Subtract 4-4: ALUFlags=0110, FlagW=10 -> Flags update to 01x0 with C,V unchanged from the prior value. Then Cond=1101 (LE) -> CondEx=1, MemW=1 -> MemWrite=1.
4. Flags=1000 (N=1,V=0), Cond=1011 (LT), FlagW=11, ALUFlags=0000 -> CondEx=1 and Flags become 0000. The same ALUFlags with Cond=1010 (GE) -> CondEx=0, Flags unchanged, PCSrc=0 despite PCS=1.
5. en=0 with FlagW=11, ALUFlags=1111, Cond=1110 -> Flags hold, all write outputs 0. Raise reset together with FlagW=11 -> Flags=FLAG_RST next cycle.
6. (COND_SQUASH_CNT_EN) With CNT_W=2, drive 5 failed-condition RegW=1 instructions -> squash_cnt goes 1,2,3,3,3. Pulse squash_clr -> 0.
